// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch next-PC unit and its branch target buffer.
// Purely declarative: no latency, no flow control.
// Saturating counter helpers never wrap past SNT/ST.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam int INSN_BYTES = 4;

    function automatic bp_ctr_t ctr_inc(input bp_ctr_t c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic bp_ctr_t ctr_dec(input bp_ctr_t c);
        case (c)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

endpackage

// File: rtl/btb_2bit.sv
// Direct-mapped BTB with 2-bit direction counters; one comb read port, one trained write port.
// Latency: read is combinational; a write lands on the next rising edge (reads see pre-edge data).
// Backpressure: none; a write is accepted every cycle it is offered.
module btb_2bit
    import pc_gen_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int IDXW        = $clog2(BTB_ENTRIES),
    parameter int TAGW        = XLEN - IDXW - 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] rd_idx,
    input  logic [TAGW-1:0] rd_tag,
    output logic            rd_hit,
    output logic            rd_taken,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  logic            wr_cf,
    input  logic            wr_jump,
    input  logic            wr_taken,
    input  logic [XLEN-1:0] wr_target
);

    logic [BTB_ENTRIES-1:0] valid_q;
    bp_ctr_t                ctr_q    [BTB_ENTRIES];
    logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];

    logic wr_hit;
    logic do_train;
    logic do_alloc;
    logic do_kill;

    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_taken  = ctr_q[rd_idx][1];
    assign rd_target = target_q[rd_idx];

    assign wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign do_train = wr_en &  wr_cf &  wr_hit;
    assign do_alloc = wr_en &  wr_cf & ~wr_hit & wr_taken;
    // a non-control-flow instruction that hit is an alias; drop the entry
    assign do_kill  = wr_en & ~wr_cf &  wr_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else begin
            if (do_alloc) begin
                valid_q[wr_idx] <= 1'b1;
                ctr_q[wr_idx]   <= wr_jump ? ST : WT;
            end else if (do_train) begin
                ctr_q[wr_idx]   <= wr_jump  ? ST :
                                   wr_taken ? ctr_inc(ctr_q[wr_idx]) : ctr_dec(ctr_q[wr_idx]);
            end else if (do_kill) begin
                valid_q[wr_idx] <= 1'b0;
            end
        end
    end

    // tag/target carry no reset: they are qualified by valid_q
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[wr_idx] <= wr_tag;
        end
        if (do_alloc || (do_train && wr_taken)) begin
            target_q[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/pc_gen_bp.sv
// IF-stage next-PC unit: PC register, BTB-based prediction, EX-resolved redirect with flush.
// Latency: prediction is combinational on pc; redirect shows on pc one edge after EX resolves.
// Backpressure: stall holds pc but never blocks a redirect or BTB training.
module pc_gen_bp
    import pc_gen_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter bit              BTB_EN      = 1'b1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush
);

    localparam int              IDXW = $clog2(BTB_ENTRIES);
    localparam int              TAGW = XLEN - IDXW - 2;
    localparam logic [XLEN-1:0] STEP = XLEN'(INSN_BYTES);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] fix_pc;
    logic            btb_hit_raw;
    logic            btb_hit;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;
    logic            cf;
    logic            mispredict;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + STEP;

    btb_2bit #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .IDXW        (IDXW),
        .TAGW        (TAGW)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_q[IDXW+1:2]),
        .rd_tag    (pc_q[XLEN-1:IDXW+2]),
        .rd_hit    (btb_hit_raw),
        .rd_taken  (btb_taken),
        .rd_target (btb_target),
        .wr_en     (ex_valid & BTB_EN),
        .wr_idx    (ex_pc[IDXW+1:2]),
        .wr_tag    (ex_pc[XLEN-1:IDXW+2]),
        .wr_cf     (cf),
        .wr_jump   (ex_is_jump),
        .wr_taken  (ex_taken),
        .wr_target (ex_target)
    );

    assign btb_hit     = btb_hit_raw & BTB_EN;
    assign pred_taken  = ~rst & btb_hit & btb_taken;
    assign pred_target = rst ? '0 : (btb_hit ? btb_target : pc_plus4);

    assign cf         = ex_is_branch | ex_is_jump;
    assign mispredict = ex_valid &
                        (cf ? ((ex_taken != ex_pred_taken) |
                               (ex_taken & (ex_target != ex_pred_target)))
                            : ex_pred_taken);
    assign flush      = mispredict;
    assign fix_pc     = (cf & ex_taken) ? ex_target : (ex_pc + STEP);

    always_comb begin
        pc_next = pc_plus4;
        if (mispredict) begin
            pc_next = fix_pc;
        end else if (stall) begin
            pc_next = pc_q;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

endmodule
